mp_add_seq: RTL

//  Multi-precision add/subtract sequencer around the team's 16-bit carry-lookahead adder.
//  - Accepts operand word pairs least-significant word first, one pair per handshake.
//  - Chains the adder carry across cycles and streams result words out with ready/valid flow control.
//  - Serves as the arithmetic engine for 16..128-bit integer ops in the lab datapath.

---
 rtl/mp_add_pkg.sv | 23 ++
 rtl/mp_add_cla16.sv | 59 +++++
 rtl/mp_add_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
package mp_add_pkg;

  // Native width of the team carry-lookahead adder.
  localparam int unsigned MP_WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mp_state_e;

  // 4-bit lookahead group: returns {group generate, group propagate}.
  function automatic logic [1:0] cla_group(input logic [3:0] g, input logic [3:0] p);
    logic gg;
    logic gp;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp = &p;
    return {gg, gp};
  endfunction

endpackage

// File: rtl/mp_add_cla16.sv
// Team 16-bit carry-lookahead adder: four 4-bit groups with a lookahead carry unit.
// Purely combinational.
module mp_add_cla16
  import mp_add_pkg::*;
(
  input  logic [MP_WORD_W-1:0] a,
  input  logic [MP_WORD_W-1:0] b,
  input  logic                 cin,
  output logic [MP_WORD_W-1:0] s,
  output logic                 cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate terms.
  always_comb begin
    logic [1:0] gp;
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < 4; k++) begin
      gp       = cla_group(g[4*k +: 4], p[4*k +: 4]);
      grp_g[k] = gp[1];
      grp_p[k] = gp[0];
    end
  end

  // Lookahead carries into each group, flattened so no group waits on another.
  assign gc[0] = cin;
  assign gc[1] = grp_g[0] | (grp_p[0] & cin);
  assign gc[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
  assign gc[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
  assign gc[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);
  assign cout  = gc[4];

  // Sum bits; carries inside a group are resolved from that group's lookahead carry.
  always_comb begin
    logic c_loc;
    s     = '0;
    c_loc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c_loc = gc[k];
      for (int j = 0; j < 4; j++) begin
        s[4*k+j] = p[4*k+j] ^ c_loc;
        c_loc    = g[4*k+j] | (p[4*k+j] & c_loc);
      end
    end
  end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams LS-word-first operand pairs through the
// 16-bit CLA adder, chaining carry across cycles, with a single-entry ready/valid output.
// Optional macro MPADD_ZFLAG_EN adds the 'zero' result flag.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int unsigned WORD_W    = MP_WORD_W,
  parameter int unsigned MAX_WORDS = 8,
  parameter int unsigned LEN_W     = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              sub,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_s,
  output logic              out_last,
  output logic              done,
  output logic              carry_out,
  output logic              overflow
`ifdef MPADD_ZFLAG_EN
  ,
  output logic              zero
`endif
);

  mp_state_e         state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_q;
  logic              sub_q;
  logic              carry_q;

  logic [WORD_W-1:0] b_eff;
  logic [WORD_W-1:0] sum;
  logic              cout;
  logic              start_go;
  logic              accept;
  logic              out_fire;
  logic              is_last;
  logic              ovf_word;

  assign b_eff    = sub_q ? ~in_b : in_b;
  assign start_go = (state_q == ST_IDLE) && start;
  assign in_ready = (state_q == ST_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // Second term keeps the counter from wrapping even if len_q were out of range.
  assign is_last  = (count_q == len_q) || (count_q == LEN_W'(MAX_WORDS - 1));
  assign ovf_word = (in_a[WORD_W-1] == b_eff[WORD_W-1]) && (sum[WORD_W-1] != in_a[WORD_W-1]);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

  mp_add_cla16 u_cla (
    .a    (in_a),
    .b    (b_eff),
    .cin  (carry_q),
    .s    (sum),
    .cout (cout)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (accept && is_last) state_d = ST_DRAIN;
      ST_DRAIN: if (out_fire && out_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operation context, carry chain, output register and result flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q     <= '0;
      count_q   <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      out_s     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (start_go) begin
        len_q     <= len;
        sub_q     <= sub;
        carry_q   <= sub;  // +1 of the two's complement for subtraction
        count_q   <= '0;
        carry_out <= 1'b0;
        overflow  <= 1'b0;
      end
      if (accept) begin
        out_s     <= sum;
        out_valid <= 1'b1;
        out_last  <= is_last;
        carry_q   <= cout;
        if (!is_last) count_q <= count_q + LEN_W'(1);
        if (is_last) begin
          carry_out <= sub_q ? ~cout : cout;  // report borrow, not carry, for subtraction
          overflow  <= ovf_word;
        end
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef MPADD_ZFLAG_EN
  logic zero_acc_q;

  // Running all-words-zero accumulator; published to 'zero' on the last accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_acc_q <= 1'b0;
      zero       <= 1'b0;
    end else if (start_go) begin
      zero_acc_q <= 1'b1;
      zero       <= 1'b0;
    end else if (accept) begin
      zero_acc_q <= zero_acc_q && (sum == '0);
      if (is_last) zero <= zero_acc_q && (sum == '0);
    end
  end
`endif

endmodule
